// File: rtl/rgf_pkg.sv
// Shared defaults, address-width derivation and word/address types for the
// multi-port register file.
package rgf_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    function automatic int rgf_aw(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    typedef logic [rgf_aw(NREGS_DEF)-1:0] rgf_addr_t;
    typedef logic [XLEN_DEF-1:0]          rgf_word_t;
endpackage

// File: rtl/rgf_scoreboard.sv
// Per-register pending flags for RAW detection; optional same-cycle clear
// forwarding when RGF_BYPASS_EN is defined.
module rgf_scoreboard import rgf_pkg::*; #(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NRD-1:0][rgf_aw(NREGS)-1:0]   rn,
    output logic [NRD-1:0]                      pend,
    input  logic                                iss_v,
    input  logic [rgf_aw(NREGS)-1:0]            iss_rd,
    input  logic [NWR-1:0]                      we,
    input  logic [NWR-1:0][rgf_aw(NREGS)-1:0]   wn,
    input  logic [NWR-1:0]                      wclr
);
    logic [NREGS-1:0] pend_q, pend_d;

    // Clears first, then the set, so a new producer supersedes a retiring one.
    always_comb begin
        pend_d = pend_q;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && wclr[j] && wn[j] != '0) pend_d[wn[j]] = 1'b0;
        end
        if (iss_v && iss_rd != '0) pend_d[iss_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < NRD; i++) begin
            pend[i] = (rn[i] != '0) && pend_q[rn[i]];
`ifdef RGF_BYPASS_EN
            begin
                logic byp_clr;
                byp_clr = 1'b0;
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && wn[j] == rn[i]) byp_clr = wclr[j];
                end
                if (byp_clr && !(iss_v && iss_rd == rn[i])) pend[i] = 1'b0;
            end
`endif
        end
    end
endmodule

// File: rtl/rgf_mp.sv
// Multi-port integer register file: NRD combinational reads, NWR prioritised
// writes, x0 hardwired to zero. RGF_BYPASS_EN enables write-to-read forwarding.
module rgf_mp import rgf_pkg::*; #(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NRD-1:0][rgf_aw(NREGS)-1:0]   rn,
    output logic [NRD-1:0][XLEN-1:0]            val,
    output logic [NRD-1:0]                      pend,
    input  logic                                iss_v,
    input  logic [rgf_aw(NREGS)-1:0]            iss_rd,
    input  logic [NWR-1:0]                      we,
    input  logic [NWR-1:0][rgf_aw(NREGS)-1:0]   wn,
    input  logic [NWR-1:0][XLEN-1:0]            data,
    input  logic [NWR-1:0]                      wclr
);
    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;

    // Ascending port order: the highest-index writer to a register lands last.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && wn[j] != '0) regs_d[wn[j]] = data[j];
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    always_comb begin
        val = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!rst && rn[i] != '0) begin
                val[i] = regs_q[rn[i]];
`ifdef RGF_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && wn[j] == rn[i]) val[i] = data[j];
                end
`endif
            end
        end
    end

    rgf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_sb (
        .clk    (clk),
        .rst    (rst),
        .rn     (rn),
        .pend   (pend),
        .iss_v  (iss_v),
        .iss_rd (iss_rd),
        .we     (we),
        .wn     (wn),
        .wclr   (wclr)
    );
endmodule

// File: tb/tb_rgf_mp.sv
// Directed bench for rgf_mp in a 3-read / 2-write build; bypass expectations
// follow RGF_BYPASS_EN.
module tb_rgf_mp;
    localparam int XLEN = 32, NREGS = 32, NRD = 3, NWR = 2, AW = 5;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NRD-1:0][AW-1:0]     rn;
    logic [NRD-1:0][XLEN-1:0]   val;
    logic [NRD-1:0]             pend;
    logic                       iss_v;
    logic [AW-1:0]              iss_rd;
    logic [NWR-1:0]             we;
    logic [NWR-1:0][AW-1:0]     wn;
    logic [NWR-1:0][XLEN-1:0]   data;
    logic [NWR-1:0]             wclr;

    int total = 0;
    int bad   = 0;

    rgf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .rst(rst), .rn(rn), .val(val), .pend(pend),
        .iss_v(iss_v), .iss_rd(iss_rd), .we(we), .wn(wn), .data(data), .wclr(wclr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_v = 1'b0; iss_rd = '0; we = '0; wn = '0; data = '0; wclr = '0;
    endtask

    initial begin
        rst = 1'b1; rn = '0; idle();
        rn[0] = 5'd5; rn[1] = 5'd7; rn[2] = 5'd3;
        #1;
        chk("rst_val0", val[0], 32'h0);
        chk("rst_val1", val[1], 32'h0);
        chk("rst_pend", {29'h0, pend}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;

        // x5 = DEADBEEF, issue x5, then reset mid-run
        we[0] = 1'b1; wn[0] = 5'd5; data[0] = 32'hDEADBEEF;
        iss_v = 1'b1; iss_rd = 5'd5;
        tick(); idle();
        chk("x5_wr", val[0], 32'hDEADBEEF);
        chk("x5_pend", {31'h0, pend[0]}, 32'h1);
        we[1] = 1'b1; wn[1] = 5'd5; data[1] = 32'h55;
        rst = 1'b1;
        #1;
        chk("rst_mid_val", val[0], 32'h0);
        chk("rst_mid_pend", {31'h0, pend[0]}, 32'h0);
        tick(); idle();
        rst = 1'b0;
        tick();
        chk("rst_post_val", val[0], 32'h0);
        chk("rst_post_pend", {31'h0, pend[0]}, 32'h0);

        // x0 is never written and never pending
        rn[0] = 5'd0;
        we[0] = 1'b1; wn[0] = 5'd0; data[0] = 32'h1234;
        iss_v = 1'b1; iss_rd = 5'd0;
        tick(); idle();
        chk("x0_val", val[0], 32'h0);
        chk("x0_pend", {31'h0, pend[0]}, 32'h0);

        // collision: port 1 wins
        we = 2'b11; wn[0] = 5'd7; wn[1] = 5'd7; data[0] = 32'h11; data[1] = 32'h22;
        tick(); idle();
        chk("collide_x7", val[1], 32'h22);

        // scoreboard set / set-beats-clear / clear / wclr without we
        iss_v = 1'b1; iss_rd = 5'd3;
        tick(); idle();
        chk("sb_set", {31'h0, pend[2]}, 32'h1);
        we[0] = 1'b1; wn[0] = 5'd3; data[0] = 32'h33; wclr[0] = 1'b1;
        iss_v = 1'b1; iss_rd = 5'd3;
        tick(); idle();
        chk("sb_setwins_pend", {31'h0, pend[2]}, 32'h1);
        chk("sb_setwins_val", val[2], 32'h33);
        wclr[1] = 1'b1; wn[1] = 5'd3;
        tick(); idle();
        chk("sb_wclr_no_we", {31'h0, pend[2]}, 32'h1);
        iss_v = 1'b1; iss_rd = 5'd3;
        tick(); idle();
        chk("sb_reissue", {31'h0, pend[2]}, 32'h1);
        we[1] = 1'b1; wn[1] = 5'd3; data[1] = 32'h34; wclr[1] = 1'b1;
        tick(); idle();
        chk("sb_clear_pend", {31'h0, pend[2]}, 32'h0);
        chk("sb_clear_val", val[2], 32'h34);

        // bypass window on x9
        rn[0] = 5'd9;
        we[0] = 1'b1; wn[0] = 5'd9; data[0] = 32'h99;
        iss_v = 1'b1; iss_rd = 5'd9;
        tick(); idle();
        chk("x9_pre_val", val[0], 32'h99);
        chk("x9_pre_pend", {31'h0, pend[0]}, 32'h1);
        we[1] = 1'b1; wn[1] = 5'd9; data[1] = 32'hCAFE; wclr[1] = 1'b1;
        #1;
`ifdef RGF_BYPASS_EN
        chk("byp_val", val[0], 32'hCAFE);
        chk("byp_pend", {31'h0, pend[0]}, 32'h0);
`else
        chk("nobyp_val", val[0], 32'h99);
        chk("nobyp_pend", {31'h0, pend[0]}, 32'h1);
`endif
        tick(); idle();
        chk("x9_post_val", val[0], 32'hCAFE);
        chk("x9_post_pend", {31'h0, pend[0]}, 32'h0);

        // multi-read
        we = 2'b11; wn[0] = 5'd1; wn[1] = 5'd2; data[0] = 32'hA; data[1] = 32'hB;
        tick(); idle();
        rn[0] = 5'd1; rn[1] = 5'd2; rn[2] = 5'd1;
        #1;
        chk("mr_p0", val[0], 32'hA);
        chk("mr_p1", val[1], 32'hB);
        chk("mr_p2", val[2], 32'hA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
